// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Purpose  : Shared definitions for the minterm checker: FSM state encoding
//             and the all-ones saturation constant used by sat_counter.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mc_pkg;

   // FSM state encoding, exported as-is on the state output.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } mc_state_e;

   // Saturation value for counters up to 64 bits wide; a W-bit counter
   // uses the low W bits, which gives 2**W-1.
   localparam logic [63:0] CNT_SAT_MAX = '1;

endpackage : mc_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : W-bit up-counter that increments on inc and sticks at 2**W-1.
//  Ports    : clk   - clock
//             reset - synchronous active-high reset (clears the count)
//             inc   - increment request for this cycle
//             count - current count value
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter
   import mc_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] C_MAX = CNT_SAT_MAX[W-1:0];

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != C_MAX)) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign count = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/minterm_checker.sv
`default_nettype none
// ============================================================================
//  Module   : minterm_checker
//  Purpose  : Evaluates a boolean function held as a serially loadable truth
//             table against test vectors, flags mismatches against expected
//             values and counts evaluated vectors and errors.
//  Ports    : clk       - clock
//             reset     - synchronous active-high reset
//             tbl_load  - shift tbl_bit into the truth table this cycle
//             tbl_bit   - serial truth-table data (bit 0 first)
//             vec_valid - vec_in / vec_exp carry a test vector
//             vec_in    - function input vector, MSB is the first variable
//             vec_exp   - expected function output for vec_in
//             done      - end-of-test request
//             y         - registered function output
//             y_valid   - one-cycle pulse qualifying y and mismatch
//             mismatch  - registered y != vec_exp
//             err_cnt   - saturating mismatch count
//             vec_cnt   - saturating evaluated-vector count
//             state     - FSM state (IDLE=0, LOAD=1, RUN=2, DONE=3)
//  Revision : 1.0 - initial release
// ============================================================================
module minterm_checker
   import mc_pkg::*;
#(
   parameter int                      N_IN       = 3,
   parameter int                      CNT_W      = 16,
   parameter logic [(2**N_IN)-1:0]    TABLE_INIT = 8'h31
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tbl_load,
   input  logic             tbl_bit,
   input  logic             vec_valid,
   input  logic [N_IN-1:0]  vec_in,
   input  logic             vec_exp,
   input  logic             done,
   output logic             y,
   output logic             y_valid,
   output logic             mismatch,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [1:0]       state
);

   localparam int              C_DEPTH     = 2**N_IN;
   // Load counter value seen while the last table bit is being accepted.
   localparam logic [N_IN-1:0] C_LOAD_LAST = '1;

   mc_state_e           state_q;
   logic [C_DEPTH-1:0]  table_q;
   logic [N_IN-1:0]     load_cnt_q;
   logic                y_q;
   logic                y_valid_q;
   logic                mismatch_q;

   logic                eval_en;
   logic                y_d;
   logic                mis_d;

   // A vector is evaluated in RUN, or in IDLE when no table bit competes
   // for the same cycle (table loading wins in IDLE).
   assign eval_en = vec_valid &&
                    (((state_q == ST_IDLE) && !tbl_load) || (state_q == ST_RUN));
   assign y_d     = table_q[vec_in];
   assign mis_d   = (y_d != vec_exp);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         table_q    <= TABLE_INIT;
         load_cnt_q <= '0;
         y_q        <= 1'b0;
         y_valid_q  <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         y_valid_q <= 1'b0;
         if (eval_en) begin
            y_q        <= y_d;
            mismatch_q <= mis_d;
            y_valid_q  <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (tbl_load) begin
                  table_q    <= {tbl_bit, table_q[C_DEPTH-1:1]};
                  load_cnt_q <= N_IN'(1);
                  state_q    <= ST_LOAD;
               end else if (vec_valid) begin
                  state_q <= ST_RUN;
               end
            end
            ST_LOAD: begin
               if (tbl_load) begin
                  table_q <= {tbl_bit, table_q[C_DEPTH-1:1]};
                  if (load_cnt_q == C_LOAD_LAST) begin
                     load_cnt_q <= '0;
                     state_q    <= ST_IDLE;
                  end else begin
                     load_cnt_q <= load_cnt_q + N_IN'(1);
                  end
               end
            end
            ST_RUN: begin
               // The vector sampled alongside done has already been handled
               // by eval_en above, so it is counted before entering DONE.
               if (done) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Terminal until reset.
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (eval_en & mis_d),
      .count (err_cnt)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_vec_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (eval_en),
      .count (vec_cnt)
   );

   assign y        = y_q;
   assign y_valid  = y_valid_q;
   assign mismatch = mismatch_q;
   assign state    = state_q;

endmodule : minterm_checker
`default_nettype wire

// File: doc/minterm_checker.md
MINTERM_CHECKER -- requirements
Module: minterm_checker

Interface
REQ-001 Parameter N_IN, default 3: number of function inputs, legal range 1..8.
REQ-002 Parameter CNT_W, default 16: width of the error and vector counters.
REQ-003 Parameter TABLE_INIT, default 8'h31 (width 2**N_IN): truth table loaded at reset; bit i is the output for input value i.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tbl_load  in  1  when high, shift tbl_bit into the truth table this cycle.
REQ-007 tbl_bit  in  1  serial truth-table data.
REQ-008 vec_valid  in  1  when high, vec_in and vec_exp hold a test vector.
REQ-009 vec_in  in  N_IN  function input vector; MSB is the first variable.
REQ-010 vec_exp  in  1  expected output for vec_in.
REQ-011 done  in  1  end-of-test request.
REQ-012 y  out  1  registered function output.
REQ-013 y_valid  out  1  one-cycle pulse qualifying y and mismatch.
REQ-014 mismatch  out  1  registered: y differs from vec_exp.
REQ-015 err_cnt  out  CNT_W  count of mismatches.
REQ-016 vec_cnt  out  CNT_W  count of evaluated vectors.
REQ-017 state  out  2  current FSM state encoding.

Function
REQ-018 FSM states SHALL be IDLE=0, LOAD=1, RUN=2, DONE=3.
REQ-019 IDLE: tbl_load -> LOAD, shifting that bit; else vec_valid -> RUN, evaluating that vector; else stay.
REQ-020 Each accepted table bit SHALL shift as table <= {tbl_bit, table[top:1]}, so the first of 2**N_IN bits lands in bit 0.
REQ-021 LOAD: a load counter SHALL count accepted bits; on the 2**N_IN-th bit, return to IDLE and clear the counter.
REQ-022 LOAD with tbl_load low: stay in LOAD and hold the partial table; ignore vec_valid and done.
REQ-023 RUN: each vec_valid cycle evaluates table[vec_in]; tbl_load is ignored.
REQ-024 Latency: y, mismatch and y_valid SHALL update exactly 1 cycle after the vec_valid edge; y_valid is low otherwise.
REQ-025 On a y_valid cycle, mismatch SHALL equal (table[vec_in] != vec_exp); otherwise mismatch holds its value.
REQ-026 vec_cnt SHALL increment per evaluated vector, and err_cnt per mismatch, both in the same cycle y_valid rises.
REQ-027 Both counters SHALL saturate at 2**CNT_W-1 and never wrap.
REQ-028 RUN with done high -> DONE; if vec_valid is also high, that vector SHALL be evaluated and counted first.
REQ-029 DONE: hold y, mismatch and counters; ignore all inputs except reset.
REQ-030 y and mismatch hold their values between y_valid pulses.

Reset
REQ-031 Reset SHALL force state=IDLE, table=TABLE_INIT, load counter=0, y=0, y_valid=0, mismatch=0, err_cnt=0, vec_cnt=0.
REQ-032 Reset SHALL take priority over all inputs in any state, including mid-LOAD; a partial table is discarded.
REQ-033 An evaluation pending when reset is sampled SHALL produce no y_valid pulse.

Structure
REQ-034 State encoding and the counter saturation constant SHALL live in a shared package, mc_pkg.
REQ-035 One sub-module, sat_counter (parameter W, synchronous reset, inc input), SHALL be instantiated for each of err_cnt and vec_cnt.
REQ-036 The truth table SHALL be a flat 2**N_IN-bit register, with no memory macros.

Verification
REQ-037 Reset, then apply vectors 000..111 with vec_exp = 1,0,0,0,1,1,0,0 -> y matches vec_exp, err_cnt=0, vec_cnt=8.
REQ-038 Shift in 8 bits (first bit first) 0,1,1,0,1,0,0,1, then apply vector 011 -> state returns to IDLE after the 8th bit; y=0 one cycle later.
REQ-039 Apply vec_in=010 with vec_exp=1 under the default table -> mismatch=1 and err_cnt=1, with y_valid pulsing exactly one cycle after vec_valid.
REQ-040 With CNT_W=2, apply 5 mismatching vectors -> err_cnt stops at 3.
REQ-041 Assert done and vec_valid together in RUN -> that vector is counted, state=DONE, and later vec_valid causes no change.
REQ-042 Assert reset after 4 of 8 table bits -> state=IDLE, table=8'h31, and vector 100 yields y=1.
